evaluate_scheduler: RTL and testbench

//  Shares one fixed-latency board evaluator (evaluate_pawns and sibling evaluate_* units behind one

---
 rtl/evaluate_scheduler_pkg.sv | 27 ++
 rtl/evaluate_scheduler_rr_arbiter.sv | 32 +++
 rtl/evaluate_scheduler.sv | 173 +++++++++++++++++
 tb/tb_evaluate_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evaluate_scheduler_pkg.sv
// Shared types and state encoding for the board-evaluation schedulers.
package evaluate_scheduler_pkg;

   // Packed board: 64 squares x 4-bit piece code.
   localparam int BOARD_WIDTH = 256;

   // Scheduler FSM encoding, reused by the other eval schedulers.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_WAIT   = 2'd2,
      ST_RETIRE = 2'd3
   } sched_state_e;

   // Everything the evaluator needs for one position.
   typedef struct packed {
      logic [BOARD_WIDTH-1:0] board;
      logic [63:0]            white_attacking;
      logic [63:0]            black_attacking;
   } eval_req_t;

   // Width of a requester index; never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/evaluate_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request after ptr wins,
// wrapping around; ptr itself has the lowest priority.
module rr_arbiter
   import evaluate_scheduler_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   // Walk candidates farthest-first so the nearest set request after ptr is the last to write.
   always_comb begin
      grant = '0;
      idx   = '0;
      cand  = '0;
      for (int off = N; off >= 1; off--) begin
         cand = IW'((int'(ptr) + off) % N);
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/evaluate_scheduler.sv
// Shares one fixed-latency board evaluator among NUM_REQ search requesters.
// One board in flight; round-robin grant; result or timeout routed back to the winner.
module evaluate_scheduler
   import evaluate_scheduler_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int EVAL_WIDTH = 24,
   parameter int TIMEOUT    = 31
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*BOARD_WIDTH-1:0] req_board,
   input  logic [NUM_REQ*64-1:0]          req_white_attacking,
   input  logic [NUM_REQ*64-1:0]          req_black_attacking,
   output logic [NUM_REQ-1:0]             req_grant,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic signed [EVAL_WIDTH-1:0]   rsp_eval_mg,
   output logic signed [EVAL_WIDTH-1:0]   rsp_eval_eg,
   output logic                           rsp_timeout,
   output logic [BOARD_WIDTH-1:0]         eval_board,
   output logic [63:0]                    eval_white_attacking,
   output logic [63:0]                    eval_black_attacking,
   output logic                           eval_board_valid,
   output logic                           eval_clear,
   input  logic signed [EVAL_WIDTH-1:0]   eval_mg,
   input  logic signed [EVAL_WIDTH-1:0]   eval_eg,
   input  logic                           eval_valid,
   output logic                           busy
);

   localparam int            IW          = idx_width(NUM_REQ);
   localparam int            CW          = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_TIMEOUT = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX     = {CW{1'b1}};
   // Pointer parks on the last requester so requester 0 wins first after reset.
   localparam logic [IW-1:0] PTR_RESET   = IW'(NUM_REQ - 1);

   // Per-requester views of the flat input buses.
   eval_req_t [NUM_REQ-1:0] req_data;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_data[g].board           = req_board[g*BOARD_WIDTH +: BOARD_WIDTH];
      assign req_data[g].white_attacking = req_white_attacking[g*64 +: 64];
      assign req_data[g].black_attacking = req_black_attacking[g*64 +: 64];
   end

   sched_state_e                  state_q, state_d;
   logic [IW-1:0]                 ptr_q, ptr_d;
   logic [IW-1:0]                 winner_q, winner_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   eval_req_t                     eval_q, eval_d;
   logic [NUM_REQ-1:0]            grant_q, grant_d;
   logic                          board_valid_q, board_valid_d;
   logic                          clear_q, clear_d;
   logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
   logic signed [EVAL_WIDTH-1:0]  rsp_mg_q, rsp_mg_d;
   logic signed [EVAL_WIDTH-1:0]  rsp_eg_q, rsp_eg_d;
   logic                          rsp_timeout_q, rsp_timeout_d;
   logic                          busy_q, busy_d;

   logic [NUM_REQ-1:0]            arb_grant;
   logic [IW-1:0]                 arb_idx;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx)
   );

   // Next-state and registered-output logic; every pulse output defaults low.
   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      winner_d      = winner_q;
      cnt_d         = cnt_q;
      eval_d        = eval_q;
      grant_d       = '0;
      board_valid_d = 1'b0;
      clear_d       = 1'b0;
      rsp_valid_d   = '0;
      rsp_mg_d      = '0;
      rsp_eg_d      = '0;
      rsp_timeout_d = 1'b0;
      case (state_q)
         // RETIRE arbitrates like IDLE so a waiting requester is granted with no idle bubble.
         ST_IDLE, ST_RETIRE: begin
            state_d = ST_IDLE;
            if (|req_valid) begin
               state_d       = ST_ISSUE;
               grant_d       = arb_grant;
               winner_d      = arb_idx;
               ptr_d         = arb_idx;
               eval_d        = req_data[arb_idx];
               board_valid_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q != CNT_MAX)
               cnt_d = cnt_q + CW'(1);
            // A result arriving on the timeout cycle still counts as a result.
            if (eval_valid) begin
               state_d               = ST_RETIRE;
               rsp_valid_d[winner_q] = 1'b1;
               rsp_mg_d              = eval_mg;
               rsp_eg_d              = eval_eg;
               clear_d               = 1'b1;
            end else if (cnt_q == CNT_TIMEOUT) begin
               state_d               = ST_RETIRE;
               rsp_valid_d[winner_q] = 1'b1;
               rsp_timeout_d         = 1'b1;
               clear_d               = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset abandons any board in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= PTR_RESET;
         winner_q      <= '0;
         cnt_q         <= '0;
         eval_q        <= '0;
         grant_q       <= '0;
         board_valid_q <= 1'b0;
         clear_q       <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_mg_q      <= '0;
         rsp_eg_q      <= '0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         winner_q      <= winner_d;
         cnt_q         <= cnt_d;
         eval_q        <= eval_d;
         grant_q       <= grant_d;
         board_valid_q <= board_valid_d;
         clear_q       <= clear_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_mg_q      <= rsp_mg_d;
         rsp_eg_q      <= rsp_eg_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign req_grant            = grant_q;
   assign rsp_valid            = rsp_valid_q;
   assign rsp_eval_mg          = rsp_mg_q;
   assign rsp_eval_eg          = rsp_eg_q;
   assign rsp_timeout          = rsp_timeout_q;
   assign eval_board           = eval_q.board;
   assign eval_white_attacking = eval_q.white_attacking;
   assign eval_black_attacking = eval_q.black_attacking;
   assign eval_board_valid     = board_valid_q;
   assign eval_clear           = clear_q;
   assign busy                 = busy_q;

endmodule

// File: tb/tb_evaluate_scheduler.sv
// Bench for evaluate_scheduler: evaluator stub, requester model and response scoreboard.
module tb_evaluate_scheduler;
   import evaluate_scheduler_pkg::*;

   localparam int NUM_REQ    = 4;
   localparam int EVAL_WIDTH = 24;
   localparam int TIMEOUT    = 31;

   logic                           clk;
   logic                           reset;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ*BOARD_WIDTH-1:0] req_board;
   logic [NUM_REQ*64-1:0]          req_white_attacking;
   logic [NUM_REQ*64-1:0]          req_black_attacking;
   logic [NUM_REQ-1:0]             req_grant;
   logic [NUM_REQ-1:0]             rsp_valid;
   logic signed [EVAL_WIDTH-1:0]   rsp_eval_mg;
   logic signed [EVAL_WIDTH-1:0]   rsp_eval_eg;
   logic                           rsp_timeout;
   logic [BOARD_WIDTH-1:0]         eval_board;
   logic [63:0]                    eval_white_attacking;
   logic [63:0]                    eval_black_attacking;
   logic                           eval_board_valid;
   logic                           eval_clear;
   logic signed [EVAL_WIDTH-1:0]   eval_mg;
   logic signed [EVAL_WIDTH-1:0]   eval_eg;
   logic                           eval_valid;
   logic                           busy;

   evaluate_scheduler #(
      .NUM_REQ    (NUM_REQ),
      .EVAL_WIDTH (EVAL_WIDTH),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .req_valid            (req_valid),
      .req_board            (req_board),
      .req_white_attacking  (req_white_attacking),
      .req_black_attacking  (req_black_attacking),
      .req_grant            (req_grant),
      .rsp_valid            (rsp_valid),
      .rsp_eval_mg          (rsp_eval_mg),
      .rsp_eval_eg          (rsp_eval_eg),
      .rsp_timeout          (rsp_timeout),
      .eval_board           (eval_board),
      .eval_white_attacking (eval_white_attacking),
      .eval_black_attacking (eval_black_attacking),
      .eval_board_valid     (eval_board_valid),
      .eval_clear           (eval_clear),
      .eval_mg              (eval_mg),
      .eval_eg              (eval_eg),
      .eval_valid           (eval_valid),
      .busy                 (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int mg;
      int eg;
      bit tmo;
      int due;
   } exp_t;

   typedef struct {
      logic [3:0] mask;
      int         lat;
      int         idx;
      int         mg;
      int         eg;
   } vec_t;

   exp_t                   sb[$];
   int                     gl_idx[$];
   int                     gl_cyc[$];
   vec_t                   tbl[9];

   int                     checks;
   int                     errors;
   int                     cyc;
   int                     stub_lat;
   int                     stub_due;
   bit                     stub_armed;
   logic signed [23:0]     stub_mg;
   logic signed [23:0]     stub_eg;
   bit                     rearm;
   int                     last_gidx;
   int                     last_rsp_cyc;

   logic [BOARD_WIDTH-1:0] slot_board[4];
   logic [63:0]            slot_white[4];
   logic [63:0]            slot_black[4];
   int                     slot_mg[4];
   int                     slot_eg[4];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
      end
   endfunction

   // Fill every requester slot; the expected winner carries (mg, eg), the others differ.
   task automatic load_slots(input int mg, input int eg, input int widx);
      for (int j = 0; j < 4; j++) begin
         int                     m;
         int                     e;
         logic signed [23:0]     m24;
         logic signed [23:0]     e24;
         logic [BOARD_WIDTH-1:0] b;
         m   = (j == widx) ? mg : mg + 7 * (j + 1);
         e   = (j == widx) ? eg : eg - 5 * (j + 1);
         m24 = m[23:0];
         e24 = e[23:0];
         b   = BOARD_WIDTH'({$urandom(), $urandom(), $urandom(), $urandom(),
                             $urandom(), $urandom(), $urandom(), $urandom()});
         b[23:0]        = m24;
         b[47:24]       = e24;
         slot_board[j]  = b;
         slot_mg[j]     = int'(m24);
         slot_eg[j]     = int'(e24);
         slot_white[j]  = {$urandom(), $urandom()};
         slot_black[j]  = {$urandom(), $urandom()};
      end
      req_board           = {slot_board[3], slot_board[2], slot_board[1], slot_board[0]};
      req_white_attacking = {slot_white[3], slot_white[2], slot_white[1], slot_white[0]};
      req_black_attacking = {slot_black[3], slot_black[2], slot_black[1], slot_black[0]};
   endtask

   // One clock: sample outputs 1ns after the edge, run stub, requesters and scoreboard.
   task automatic step();
      logic [1:0] gi;
      logic [1:0] ri;
      exp_t       e;
      @(posedge clk);
      #1;
      cyc++;
      if (eval_clear) begin
         eval_valid = 1'b0;
         stub_armed = 1'b0;
      end
      if (|req_grant) begin
         gi = '0;
         for (int j = 0; j < 4; j++) if (req_grant[j]) gi = 2'(j);
         chk("grant_onehot", 64'($countones(req_grant)), 64'd1);
         chk("board_valid_with_grant", eval_board_valid, 1'b1);
         chk("eval_board_data", eval_board === slot_board[gi], 1'b1);
         chk("eval_white", eval_white_attacking, slot_white[gi]);
         chk("eval_black", eval_black_attacking, slot_black[gi]);
         e.idx = int'(gi);
         e.tmo = (stub_lat == 0) || (stub_lat > TIMEOUT + 1);
         e.mg  = e.tmo ? 0 : slot_mg[gi];
         e.eg  = e.tmo ? 0 : slot_eg[gi];
         e.due = cyc + (e.tmo ? TIMEOUT + 2 : stub_lat + 1);
         sb.push_back(e);
         gl_idx.push_back(int'(gi));
         gl_cyc.push_back(cyc);
         last_gidx     = int'(gi);
         req_valid[gi] = 1'b0;
      end
      if (eval_board_valid) begin
         stub_armed = (stub_lat != 0);
         stub_due   = cyc + stub_lat;
         stub_mg    = eval_board[23:0];
         stub_eg    = eval_board[47:24];
      end
      if (stub_armed && cyc == stub_due) begin
         eval_valid = 1'b1;
         eval_mg    = stub_mg;
         eval_eg    = stub_eg;
         stub_armed = 1'b0;
      end
      if (|rsp_valid) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, '0);
         end else begin
            e  = sb.pop_front();
            ri = '0;
            for (int j = 0; j < 4; j++) if (rsp_valid[j]) ri = 2'(j);
            chk("rsp_onehot", 64'($countones(rsp_valid)), 64'd1);
            chk("rsp_idx", ri, e.idx);
            chk("rsp_mg", rsp_eval_mg, e.mg);
            chk("rsp_eg", rsp_eval_eg, e.eg);
            chk("rsp_timeout", rsp_timeout, e.tmo);
            chk("rsp_cycle", cyc, e.due);
            chk("clear_with_rsp", eval_clear, 1'b1);
            last_rsp_cyc = cyc;
            if (rearm) req_valid[ri] = 1'b1;
         end
      end else if (eval_clear) begin
         chk("clear_without_rsp", eval_clear, 1'b0);
      end
   endtask

   // Run until nothing is pending or in flight; an exhausted budget is a failure.
   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || req_valid != '0 || busy) && n < 120) begin
         step();
         n++;
      end
      if (n >= 120) chk({tag, "_drain_budget"}, n, 0);
   endtask

   // Raise mask from idle, check the first grant, then let everything retire.
   task automatic run_txn(input logic [3:0] mask, input int lat, input int exp_idx, input bit drop_others);
      int s;
      int n;
      bit got;
      stub_lat     = lat;
      req_valid    = mask;
      last_rsp_cyc = -1;
      s   = cyc;
      got = 1'b0;
      n   = 0;
      while (!got && n < 10) begin
         step();
         n++;
         if (|req_grant) got = 1'b1;
      end
      if (!got) begin
         chk("grant_seen", got, 1'b1);
      end else begin
         chk("grant_cycle", cyc, s + 1);
         chk("grant_idx", last_gidx, exp_idx);
      end
      if (drop_others) req_valid = '0;
      drain("txn");
      chk("busy_low_after_rsp", cyc, last_rsp_cyc + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      checks = 0; errors = 0; cyc = 0;
      reset = 1'b0; req_valid = '0;
      req_board = '0; req_white_attacking = '0; req_black_attacking = '0;
      eval_valid = 1'b0; eval_mg = '0; eval_eg = '0;
      stub_lat = 1; stub_armed = 1'b0; stub_due = 0; stub_mg = '0; stub_eg = '0;
      rearm = 1'b0; last_gidx = -1; last_rsp_cyc = -1;

      tbl[0] = '{4'b0100,  7, 2,       35,     -12};
      tbl[1] = '{4'b1111,  3, 3, -8388608, 8388607};
      tbl[2] = '{4'b1111,  1, 0,        0,      -1};
      tbl[3] = '{4'b0001,  5, 0,      123,     456};
      tbl[4] = '{4'b1001,  2, 3,      -77,      77};
      tbl[5] = '{4'b0110, 32, 1,      500,    -500};
      tbl[6] = '{4'b0100,  0, 2,      900,     901};
      tbl[7] = '{4'b1000, 33, 3,      -40,      40};
      tbl[8] = '{4'b0010,  4, 1,     1234,   -4321};

      // Reset state.
      step();
      step();
      chk("rst_grant", req_grant, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_mg", rsp_eval_mg, '0);
      chk("rst_eg", rsp_eval_eg, '0);
      chk("rst_timeout", rsp_timeout, 1'b0);
      chk("rst_board_zero", eval_board === '0, 1'b1);
      chk("rst_white", eval_white_attacking, '0);
      chk("rst_black", eval_black_attacking, '0);
      chk("rst_board_valid", eval_board_valid, 1'b0);
      chk("rst_clear", eval_clear, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b1;

      // Vector table: single transactions from idle, expected winner given by round-robin order.
      for (int t = 0; t < 9; t++) begin
         load_slots(tbl[t].mg, tbl[t].eg, tbl[t].idx);
         run_txn(tbl[t].mask, tbl[t].lat, tbl[t].idx, 1'b1);
      end

      // Spurious eval_valid while idle is ignored.
      eval_valid = 1'b1;
      step();
      eval_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("spur_busy", busy, 1'b0);
         chk("spur_rsp", rsp_valid, '0);
      end
      load_slots(77, -88, 0);
      run_txn(4'b0001, 2, 0, 1'b1);

      // Reset in WAIT abandons the board; afterwards requester 0 wins over 3.
      load_slots(10, 20, 1);
      stub_lat  = 0;
      req_valid = 4'b0010;
      n = 0;
      while (req_grant == '0 && n < 10) begin
         step();
         n++;
      end
      chk("abort_grant_seen", n < 10, 1'b1);
      for (int k = 0; k < 4; k++) step();
      #2;
      reset = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_rsp_valid", rsp_valid, '0);
      chk("abort_board_valid", eval_board_valid, 1'b0);
      chk("abort_clear", eval_clear, 1'b0);
      chk("abort_board_zero", eval_board === '0, 1'b1);
      sb.delete();
      eval_valid = 1'b0;
      stub_armed = 1'b0;
      req_valid  = '0;
      step();
      step();
      chk("abort_rsp_in_reset", rsp_valid, '0);
      reset = 1'b1;
      load_slots(-3, 3, 0);
      run_txn(4'b1001, 3, 0, 1'b0);

      // Fairness: all requesters keep re-requesting; grants rotate 0,1,2,3,0 spaced L+2.
      load_slots(-500, 600, 0);
      gl_idx.delete();
      gl_cyc.delete();
      rearm     = 1'b1;
      stub_lat  = 5;
      req_valid = 4'b1111;
      n = 0;
      while (gl_idx.size() < 5 && n < 100) begin
         step();
         n++;
      end
      rearm     = 1'b0;
      req_valid = '0;
      drain("fair");
      chk("fair_count", gl_idx.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < gl_idx.size()) begin
            chk("fair_idx", gl_idx[k], k % 4);
            if (k > 0) chk("fair_spacing", gl_cyc[k] - gl_cyc[k-1], 5 + 2);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
